arith_result_fifo: RTL

Downstream capture stage for the synchronous arithmetic unit. It takes the unit's registered result and 4-bit status when the issuing logic marks them valid, and buffers them in a small show-ahead FIFO. The buffered results are presented to the consumer over a valid/ready handshake. The block also keeps saturating error and drop counters for debug readout.

---
 rtl/arith_pkg.sv | 16 +
 rtl/arith_flag_gen.sv | 18 +
 rtl/arith_result_fifo.sv | 113 +++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic unit and its downstream result FIFO.
// Status bit positions and the packed result/status entry at the unit's native width.
package arith_pkg;

  localparam int unsigned ARITH_M    = 32;
  localparam int unsigned ERROR      = 3;
  localparam int unsigned NOT_EVEN_1 = 2;
  localparam int unsigned ZEROS      = 1;
  localparam int unsigned OVERFLOW   = 0;

  typedef struct packed {
    logic [3:0]         status;
    logic [ARITH_M-1:0] result;
  } arith_entry_t;

endpackage

// File: rtl/arith_flag_gen.sv
// Combinational zero and odd-parity detector over an M-bit result.
// Used by arith_result_fifo only when ARITH_FLAG_FILL_EN is defined.
module arith_flag_gen #(
  parameter int unsigned M = 32
) (
  input  logic [M-1:0] result,
  output logic         zero_flag,
  output logic         odd_flag
);

  function automatic logic odd_parity(input logic [M-1:0] value);
    return ^value;
  endfunction

  assign zero_flag = (result == {M{1'b0}});
  assign odd_flag  = odd_parity(result);

endmodule

// File: rtl/arith_result_fifo.sv
// Show-ahead capture FIFO for arithmetic-unit results with saturating error/drop counters.
// Optional macro ARITH_FLAG_FILL_EN ORs derived ZEROS / NOT_EVEN_1 flags into stored status.
module arith_result_fifo
  import arith_pkg::*;
#(
  parameter int unsigned M     = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     i_reset,
  input  logic                     i_valid,
  input  logic [M-1:0]             i_result,
  input  logic [3:0]               i_status,
  input  logic                     i_ready,
  output logic                     o_valid,
  output logic [M-1:0]             o_data,
  output logic [3:0]               o_status,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [7:0]               o_err_cnt,
  output logic [7:0]               o_drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned EW = M + 4;

  logic [EW-1:0] mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [7:0]    err_cnt_r;
  logic [7:0]    drop_cnt_r;

  logic          empty_s;
  logic          full_s;
  logic          pop_s;
  logic          push_s;
  logic          drop_s;
  logic [M-1:0]  wr_result_s;
  logic [3:0]    wr_status_s;
  logic [EW-1:0] head_s;

  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
  assign pop_s   = i_ready && !empty_s;
  assign push_s  = i_valid && (!full_s || pop_s);
  assign drop_s  = i_valid && full_s && !pop_s;

`ifdef ARITH_FLAG_FILL_EN
  logic zero_flag_s;
  logic odd_flag_s;

  arith_flag_gen #(.M(M)) u_flag_gen (
    .result    (wr_result_s),
    .zero_flag (zero_flag_s),
    .odd_flag  (odd_flag_s)
  );
`endif

  // Sanitise the incoming result on ERROR and build the status to store.
  always_comb begin
    wr_status_s = i_status;
    if (i_status[ERROR]) begin
      wr_result_s = {M{1'b0}};
    end else begin
      wr_result_s = i_result;
    end
`ifdef ARITH_FLAG_FILL_EN
    wr_status_s[ZEROS]      = i_status[ZEROS] | zero_flag_s;
    wr_status_s[NOT_EVEN_1] = i_status[NOT_EVEN_1] | odd_flag_s;
`endif
  end

  // Storage, pointers and saturating debug counters.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_r[i] <= {EW{1'b0}};
      end
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      err_cnt_r  <= 8'd0;
      drop_cnt_r <= 8'd0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= {wr_status_s, wr_result_s};
        wr_ptr_r                <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
        if (wr_status_s[ERROR] && (err_cnt_r != 8'd255)) begin
          err_cnt_r <= err_cnt_r + 8'd1;
        end
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      end
      if (drop_s && (drop_cnt_r != 8'd255)) begin
        drop_cnt_r <= drop_cnt_r + 8'd1;
      end
    end
  end

  // Head is forced to zero when empty so stale storage never leaks out.
  assign head_s     = empty_s ? {EW{1'b0}} : mem_r[rd_ptr_r[AW-1:0]];
  assign o_data     = head_s[M-1:0];
  assign o_status   = head_s[EW-1:M];
  assign o_valid    = !empty_s;
  assign o_empty    = empty_s;
  assign o_full     = full_s;
  assign o_count    = wr_ptr_r - rd_ptr_r;
  assign o_err_cnt  = err_cnt_r;
  assign o_drop_cnt = drop_cnt_r;

endmodule
